timer_set_seq: RTL and testbench

Set-mode sequencer that sits between the debounced button layer and the timer datapath.
- Owns the hour/min/sec field cursor.
- Converts held Up/Down buttons into single-cycle increment/decrement pulses with hold-then-auto-repeat.
- Exits set mode on user request, on mode loss, or on an inactivity timeout.

---
 rtl/timer_set_seq.sv | 199 +++++++++++++++++++
 tb/tb_timer_set_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_set_seq.sv
// Set-mode sequencer for the timer. It tracks the hour/min/sec cursor, turns held Up/Down
// buttons into hold-then-repeat command pulses, and leaves set mode on request or timeout.
module timer_set_seq #(
  parameter int unsigned HOLD_CYC    = 50_000_000,
  parameter int unsigned REPEAT_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEnable,
  input  logic iSet,
  input  logic iBtn_U,
  input  logic iBtn_D,
  input  logic iBtn_L,
  input  logic iBtn_R,
  output logic oSetting,
  output logic oSet_Hour,
  output logic oSet_Min,
  output logic oSet_Sec,
  output logic oHour_Up,
  output logic oHour_Down,
  output logic oMin_Up,
  output logic oMin_Down,
  output logic oSec_Up,
  output logic oSec_Down,
  output logic oTimeout
);

  localparam int unsigned RepMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam int unsigned ToW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StSelHour, StSelMin, StSelSec} state_e;
  typedef enum logic [1:0] {StRIdle, StRHold, StRRepeat} rep_e;

  state_e          r_state, w_state_d;
  rep_e            r_rep, w_rep_d;
  logic            r_dir_up, w_dir_up_d;
  logic [RepW-1:0] r_rep_cnt, w_rep_cnt_d;
  logic [ToW-1:0]  r_to_cnt, w_to_cnt_d;
  logic            r_vu_prev, r_vd_prev, r_l_prev, r_r_prev;
  logic            r_setting, r_set_hour, r_set_min, r_set_sec;
  logic [5:0]      r_cmd, w_cmd_d;
  logic            r_timeout, w_timeout_d;

  logic            w_vu, w_vd, w_vu_rise, w_vd_rise, w_l_rise, w_r_rise;
  logic            w_any_btn, w_move, w_held, w_fire, w_fire_up;
  logic [RepW-1:0] w_rep_lim;

  // Up and Down together cancel each other, so only a lone direction is a command.
  assign w_vu      = iBtn_U & ~iBtn_D;
  assign w_vd      = iBtn_D & ~iBtn_U;
  assign w_vu_rise = w_vu & ~r_vu_prev;
  assign w_vd_rise = w_vd & ~r_vd_prev;
  assign w_l_rise  = iBtn_L & ~r_l_prev;
  assign w_r_rise  = iBtn_R & ~r_r_prev;
  assign w_any_btn = iBtn_U | iBtn_D | iBtn_L | iBtn_R;
  assign w_move    = w_l_rise ^ w_r_rise;
  assign w_held    = r_dir_up ? w_vu : w_vd;
  assign w_rep_lim = (r_rep == StRHold) ? RepW'(HOLD_CYC - 1) : RepW'(REPEAT_CYC - 1);

  always_comb begin
    w_state_d   = r_state;
    w_rep_d     = r_rep;
    w_dir_up_d  = r_dir_up;
    w_rep_cnt_d = r_rep_cnt;
    w_to_cnt_d  = r_to_cnt;
    w_timeout_d = 1'b0;
    w_fire      = 1'b0;
    w_fire_up   = 1'b0;

    if (!iEnable) begin
      w_state_d   = StIdle;
      w_rep_d     = StRIdle;
      w_rep_cnt_d = '0;
      w_to_cnt_d  = '0;
    end else if (r_state == StIdle) begin
      w_rep_d     = StRIdle;
      w_rep_cnt_d = '0;
      w_to_cnt_d  = '0;
      if (iSet) begin
        w_state_d = StSelSec;
      end
    end else if (iSet) begin
      w_state_d   = StIdle;
      w_rep_d     = StRIdle;
      w_rep_cnt_d = '0;
      w_to_cnt_d  = '0;
    end else if (!w_any_btn && (r_to_cnt == ToW'(TIMEOUT_CYC - 1))) begin
      w_state_d   = StIdle;
      w_rep_d     = StRIdle;
      w_rep_cnt_d = '0;
      w_to_cnt_d  = '0;
      w_timeout_d = 1'b1;
    end else begin
      w_to_cnt_d = w_any_btn ? '0 : r_to_cnt + ToW'(1);
      if (w_move) begin
        // A cursor move abandons any held direction; the user must press again.
        w_rep_d     = StRIdle;
        w_rep_cnt_d = '0;
        if (w_l_rise) begin
          unique case (r_state)
            StSelSec:  w_state_d = StSelMin;
            StSelMin:  w_state_d = StSelHour;
            StSelHour: w_state_d = StSelSec;
            default:   w_state_d = StIdle;
          endcase
        end else begin
          unique case (r_state)
            StSelHour: w_state_d = StSelMin;
            StSelMin:  w_state_d = StSelSec;
            StSelSec:  w_state_d = StSelHour;
            default:   w_state_d = StIdle;
          endcase
        end
      end else if (w_vu_rise || w_vd_rise) begin
        w_fire      = 1'b1;
        w_fire_up   = w_vu_rise;
        w_dir_up_d  = w_vu_rise;
        w_rep_d     = StRHold;
        w_rep_cnt_d = '0;
      end else if ((r_rep != StRIdle) && w_held) begin
        if (r_rep_cnt == w_rep_lim) begin
          w_fire      = 1'b1;
          w_fire_up   = r_dir_up;
          w_rep_d     = StRRepeat;
          w_rep_cnt_d = '0;
        end else begin
          w_rep_cnt_d = r_rep_cnt + RepW'(1);
        end
      end else begin
        w_rep_d     = StRIdle;
        w_rep_cnt_d = '0;
      end
    end
  end

  // Command bits: {hour_up, hour_down, min_up, min_down, sec_up, sec_down}.
  always_comb begin
    w_cmd_d = '0;
    if (w_fire) begin
      unique case (r_state)
        StSelHour: w_cmd_d = w_fire_up ? 6'b100000 : 6'b010000;
        StSelMin:  w_cmd_d = w_fire_up ? 6'b001000 : 6'b000100;
        StSelSec:  w_cmd_d = w_fire_up ? 6'b000010 : 6'b000001;
        default:   w_cmd_d = '0;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state    <= StIdle;
      r_rep      <= StRIdle;
      r_dir_up   <= 1'b0;
      r_rep_cnt  <= '0;
      r_to_cnt   <= '0;
      r_vu_prev  <= 1'b0;
      r_vd_prev  <= 1'b0;
      r_l_prev   <= 1'b0;
      r_r_prev   <= 1'b0;
      r_setting  <= 1'b0;
      r_set_hour <= 1'b0;
      r_set_min  <= 1'b0;
      r_set_sec  <= 1'b0;
      r_cmd      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_rep      <= w_rep_d;
      r_dir_up   <= w_dir_up_d;
      r_rep_cnt  <= w_rep_cnt_d;
      r_to_cnt   <= w_to_cnt_d;
      r_vu_prev  <= w_vu;
      r_vd_prev  <= w_vd;
      r_l_prev   <= iBtn_L;
      r_r_prev   <= iBtn_R;
      r_setting  <= (w_state_d != StIdle);
      r_set_hour <= (w_state_d == StSelHour);
      r_set_min  <= (w_state_d == StSelMin);
      r_set_sec  <= (w_state_d == StSelSec);
      r_cmd      <= w_cmd_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign oSetting   = r_setting;
  assign oSet_Hour  = r_set_hour;
  assign oSet_Min   = r_set_min;
  assign oSet_Sec   = r_set_sec;
  assign oHour_Up   = r_cmd[5];
  assign oHour_Down = r_cmd[4];
  assign oMin_Up    = r_cmd[3];
  assign oMin_Down  = r_cmd[2];
  assign oSec_Up    = r_cmd[1];
  assign oSec_Down  = r_cmd[0];
  assign oTimeout   = r_timeout;

endmodule

// File: tb/tb_timer_set_seq.sv
// Scoreboard bench for timer_set_seq: directed scenarios followed by random button traffic,
// checked against a time-stamp based model of set mode and hold/repeat timing.
module tb_timer_set_seq;

  localparam int unsigned Hold = 8;
  localparam int unsigned Rep  = 4;
  localparam int unsigned To   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, set = 1'b0, bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic o_setting, o_hour, o_min, o_sec;
  logic o_hu, o_hd, o_mu, o_md, o_su, o_sd, o_tmo;

  timer_set_seq #(
    .HOLD_CYC   (Hold),
    .REPEAT_CYC (Rep),
    .TIMEOUT_CYC(To)
  ) u_dut (
    .iClk      (clk),
    .iRst      (rst),
    .iEnable   (en),
    .iSet      (set),
    .iBtn_U    (bu),
    .iBtn_D    (bd),
    .iBtn_L    (bl),
    .iBtn_R    (br),
    .oSetting  (o_setting),
    .oSet_Hour (o_hour),
    .oSet_Min  (o_min),
    .oSet_Sec  (o_sec),
    .oHour_Up  (o_hu),
    .oHour_Down(o_hd),
    .oMin_Up   (o_mu),
    .oMin_Down (o_md),
    .oSec_Up   (o_su),
    .oSec_Down (o_sd),
    .oTimeout  (o_tmo)
  );

  logic [10:0] dut_vec;
  assign dut_vec = {o_setting, o_hour, o_min, o_sec, o_hu, o_hd, o_mu, o_md, o_su, o_sd, o_tmo};

  logic [10:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Model state: cursor 0=sec 1=min 2=hour; press time is the cycle of the qualifying edge.
  bit m_sel = 1'b0;
  int m_cur = 0;
  int m_press = -1;
  bit m_up = 1'b0;
  int m_last = 0;
  int m_t = 0;
  bit p_u = 1'b0, p_d = 1'b0, p_l = 1'b0, p_r = 1'b0;

  task automatic model(output logic [10:0] e);
    bit vu, vd, ur, dr, lr, rr, any, pulse, pup, tmo;
    int k;
    pulse = 1'b0;
    pup   = 1'b0;
    tmo   = 1'b0;
    vu  = bu && !bd;
    vd  = bd && !bu;
    ur  = vu && !(p_u && !p_d);
    dr  = vd && !(p_d && !p_u);
    lr  = bl && !p_l;
    rr  = br && !p_r;
    any = bu || bd || bl || br;
    if (!rst) begin
      m_sel = 1'b0;
      m_press = -1;
      p_u = 1'b0; p_d = 1'b0; p_l = 1'b0; p_r = 1'b0;
    end else begin
      if (!en) begin
        m_sel = 1'b0;
        m_press = -1;
      end else if (!m_sel) begin
        m_press = -1;
        if (set) begin
          m_sel  = 1'b1;
          m_cur  = 0;
          m_last = m_t;
        end
      end else if (set) begin
        m_sel = 1'b0;
        m_press = -1;
      end else if (!any && (m_t - m_last == int'(To))) begin
        m_sel = 1'b0;
        m_press = -1;
        tmo = 1'b1;
      end else begin
        if (any) m_last = m_t;
        if (lr != rr) begin
          m_cur = lr ? (m_cur + 1) % 3 : (m_cur + 2) % 3;
          m_press = -1;
        end else if (ur || dr) begin
          m_press = m_t;
          m_up = ur;
          pulse = 1'b1;
          pup = ur;
        end else if (m_press >= 0 && (m_up ? vu : vd)) begin
          k = m_t - m_press;
          if (k == int'(Hold) || (k > int'(Hold) && ((k - int'(Hold)) % int'(Rep)) == 0)) begin
            pulse = 1'b1;
            pup = m_up;
          end
        end else begin
          m_press = -1;
        end
      end
      p_u = bu; p_d = bd; p_l = bl; p_r = br;
    end
    e = {m_sel, m_sel && m_cur == 2, m_sel && m_cur == 1, m_sel && m_cur == 0,
         pulse && m_cur == 2 && pup, pulse && m_cur == 2 && !pup,
         pulse && m_cur == 1 && pup, pulse && m_cur == 1 && !pup,
         pulse && m_cur == 0 && pup, pulse && m_cur == 0 && !pup, tmo};
    m_t++;
  endtask

  // Inputs are changed at a falling edge; each tick models the coming rising edge.
  task automatic tick(input int n);
    logic [10:0] ev;
    for (int i = 0; i < n; i++) begin
      model(ev);
      exp_q.push_back(ev);
      @(negedge clk);
    end
  endtask

  task automatic press(input int which);
    case (which)
      0: bl = 1'b1;
      1: br = 1'b1;
      2: bu = 1'b1;
      default: bd = 1'b1;
    endcase
    tick(1);
    bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
    tick(1);
  endtask

  task automatic set_pulse();
    set = 1'b1;
    tick(1);
    set = 1'b0;
    tick(1);
  endtask

  always @(posedge clk) begin
    logic [10:0] ev;
    #1;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      total++;
      if (dut_vec !== ev) begin
        bad++;
        $display("FAIL outvec t=%0t got=%b want=%b (set,h,m,s,hu,hd,mu,md,su,sd,tmo)",
                 $time, dut_vec, ev);
      end
    end
  end

  int quiet = 0;

  initial begin
    @(negedge clk);
    tick(2);
    rst = 1'b1;
    en  = 1'b1;
    set_pulse();
    press(0); press(0); press(0);
    press(1);
    press(1);
    bu = 1'b1; tick(2); bu = 1'b0; tick(3);
    press(0);
    bd = 1'b1; tick(20); bd = 1'b0; tick(5);
    press(1); press(1);
    bu = 1'b1; tick(12);
    bd = 1'b1; tick(6);
    bu = 1'b0; tick(10);
    bd = 1'b0; tick(3);
    tick(40);
    set_pulse();
    bl = 1'b1; tick(60); bl = 1'b0; tick(3);
    set = 1'b1; bu = 1'b1; tick(1); set = 1'b0; bu = 1'b0; tick(2);
    set_pulse();
    set = 1'b1; bd = 1'b1; tick(1); set = 1'b0; bd = 1'b0; tick(2);
    bu = 1'b1; tick(15);
    rst = 1'b0; tick(1);
    rst = 1'b1; tick(2);
    bu = 1'b0; tick(1);
    set_pulse();
    bl = 1'b1; br = 1'b1; tick(1); bl = 1'b0; br = 1'b0; tick(1);
    bu = 1'b1; tick(3);
    en = 1'b0; tick(2);
    en = 1'b1; bu = 1'b0; tick(2);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      en  = ($urandom_range(0, 249) != 0);
      set = ($urandom_range(0, 79) == 0);
      if (quiet == 0 && $urandom_range(0, 299) == 0) quiet = 45;
      if (quiet > 0) begin
        quiet--;
        bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
      end else begin
        if ($urandom_range(0, 11) == 0) bu = ~bu;
        if ($urandom_range(0, 13) == 0) bd = ~bd;
        if ($urandom_range(0, 19) == 0) bl = ~bl;
        if ($urandom_range(0, 19) == 0) br = ~br;
      end
      tick(1);
    end

    rst = 1'b1; en = 1'b1; set = 1'b0; bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
    tick(2);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
